// File: rtl/alu_sequencer_pkg.sv
// Shared widths and FSM encoding for the ALU sequencer, the pin wrapper and the alu.
package alu_sequencer_pkg;
    localparam int DATA_W_DEF  = 4;
    localparam int OP_W_DEF    = 3;
    localparam int RES_W_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int ALU_LAT_DEF = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;
endpackage

// File: rtl/alu_sequencer_cmd_fifo.sv
// Register FIFO holding packed {opcode, a, b, chain} host commands.
module seq_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// Sequences queued host commands through the shared ALU and streams results back.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ALU_LAT = ALU_LAT_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic              alu_en,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [DATA_W-1:0] alu_in_2,
    input  logic [RES_W-1:0]  alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic [7:0]        done_cnt
);
    localparam int CMD_W = OP_W + 2*DATA_W + 1;
    localparam int WC_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]        state;
    logic [WC_W-1:0]   wait_cnt;
    logic [CMD_W-1:0]  head;
    logic              full, empty, pop;
    logic [DATA_W-1:0] last_res;
    logic [DATA_W-1:0] mux_a;
    logic [RES_W-1:0]  res_q;

    seq_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .din   ({cmd_op, cmd_a, cmd_b, cmd_chain}),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Chained commands take operand A from the previous result as it stands at pop time.
    assign mux_a = head[0] ? last_res : head[2*DATA_W:DATA_W+1];
    assign pop   = !empty && ((state == ST_IDLE) || (state == ST_RESULT && res_ready));

    assign cmd_ready = !full;
    assign alu_en    = (state == ST_ISSUE);
    assign res_valid = (state == ST_RESULT);
    assign res_data  = res_q;
    assign busy      = (state != ST_IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            alu_opcode <= '0;
            alu_in_1   <= '0;
            alu_in_2   <= '0;
            last_res   <= '0;
            res_q      <= '0;
            done_cnt   <= '0;
        end else begin
            if (pop) begin
                alu_opcode <= head[CMD_W-1:2*DATA_W+1];
                alu_in_1   <= mux_a;
                alu_in_2   <= head[DATA_W:1];
            end
            case (state)
                ST_IDLE: if (!empty) state <= ST_ISSUE;
                ST_ISSUE: begin
                    wait_cnt <= WC_W'(ALU_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        res_q    <= alu_out;
                        last_res <= alu_out[DATA_W-1:0];
                        state    <= ST_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                    if (res_ready) begin
                        done_cnt <= done_cnt + 8'd1;
                        state    <= empty ? ST_IDLE : ST_ISSUE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one DUT with ALU latency 1, one with latency 3.
module tb_alu_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sel, cmd_valid, cmd_chain, res_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    int         tests = 0, fails = 0;
    int         exp_done [2];

    logic       d1_cmd_ready, d1_alu_en, d1_res_valid, d1_busy;
    logic [2:0] d1_alu_opcode;
    logic [3:0] d1_alu_in_1, d1_alu_in_2;
    logic [7:0] d1_alu_out, d1_res_data, d1_done_cnt;
    logic       d3_cmd_ready, d3_alu_en, d3_res_valid, d3_busy;
    logic [2:0] d3_alu_opcode;
    logic [3:0] d3_alu_in_1, d3_alu_in_2;
    logic [7:0] d3_alu_out, d3_res_data, d3_done_cnt;
    logic [7:0] p3 [3];

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    alu_f = {4'b0, a} + {4'b0, b};
            3'd1:    alu_f = {4'b0, a} - {4'b0, b};
            3'd2:    alu_f = {4'b0, a & b};
            3'd3:    alu_f = {4'b0, a | b};
            3'd4:    alu_f = {4'b0, a ^ b};
            3'd5:    alu_f = {4'b0, a} * {4'b0, b};
            default: alu_f = {4'b0, a};
        endcase
    endfunction

    always @(posedge clk) if (d1_alu_en) d1_alu_out <= alu_f(d1_alu_opcode, d1_alu_in_1, d1_alu_in_2);
    always @(posedge clk) begin
        if (d3_alu_en) p3[0] <= alu_f(d3_alu_opcode, d3_alu_in_1, d3_alu_in_2);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d3_alu_out = p3[2];

    alu_sequencer #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && !sel), .cmd_ready(d1_cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_en(d1_alu_en), .alu_opcode(d1_alu_opcode), .alu_in_1(d1_alu_in_1), .alu_in_2(d1_alu_in_2),
        .alu_out(d1_alu_out), .res_valid(d1_res_valid), .res_ready(res_ready), .res_data(d1_res_data),
        .busy(d1_busy), .done_cnt(d1_done_cnt));

    alu_sequencer #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid && sel), .cmd_ready(d3_cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_en(d3_alu_en), .alu_opcode(d3_alu_opcode), .alu_in_1(d3_alu_in_1), .alu_in_2(d3_alu_in_2),
        .alu_out(d3_alu_out), .res_valid(d3_res_valid), .res_ready(res_ready), .res_data(d3_res_data),
        .busy(d3_busy), .done_cnt(d3_done_cnt));

    wire       o_cmd_ready = sel ? d3_cmd_ready : d1_cmd_ready;
    wire       o_alu_en    = sel ? d3_alu_en    : d1_alu_en;
    wire       o_res_valid = sel ? d3_res_valid : d1_res_valid;
    wire       o_busy      = sel ? d3_busy      : d1_busy;
    wire [2:0] o_opcode    = sel ? d3_alu_opcode : d1_alu_opcode;
    wire [3:0] o_in_1      = sel ? d3_alu_in_1  : d1_alu_in_1;
    wire [3:0] o_in_2      = sel ? d3_alu_in_2  : d1_alu_in_2;
    wire [7:0] o_res_data  = sel ? d3_res_data  : d1_res_data;
    wire [7:0] o_done_cnt  = sel ? d3_done_cnt  : d1_done_cnt;

    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_done[0] = 0; exp_done[1] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b0; cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b exp 1", o_cmd_ready); end
        tests++; if ({o_alu_en, o_res_valid, o_busy} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b exp 000", {o_alu_en, o_res_valid, o_busy}); end
        tests++; if ({o_done_cnt, o_res_data, o_in_1, o_in_2, o_opcode} !== 27'd0) begin fails++; $display("FAIL reset_data: got %h exp 0", {o_done_cnt, o_res_data, o_in_1, o_in_2, o_opcode}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(3'd0, 4'h9, 4'h6, 1'b0);
        @(posedge clk); #1;
        tests++; if (o_alu_en !== 1'b1) begin fails++; $display("FAIL reset_pre_issue: got %b exp 1", o_alu_en); end
        @(posedge clk); #1;
        tests++; if ({o_alu_en, o_busy} !== 2'b01) begin fails++; $display("FAIL reset_pre_wait: got %b exp 01", {o_alu_en, o_busy}); end
        rst_n = 1'b0;
        #1;
        tests++; if ({o_alu_en, o_res_valid, o_busy, o_cmd_ready} !== 4'b0001) begin fails++; $display("FAIL reset_mid_wait: got %b exp 0001", {o_alu_en, o_res_valid, o_busy, o_cmd_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (o_done_cnt !== 8'd0) begin fails++; $display("FAIL reset_done_cnt: got %0d exp 0", o_done_cnt); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (o_res_valid !== 1'b0) begin fails++; $display("FAIL reset_discard: got %b exp 0", o_res_valid); end
        exp_done[0] = 0; exp_done[1] = 0;
    endtask

    task automatic test_single(input int lat);
        res_ready = 1'b0;
        push(3'd0, 4'h3, 4'h5, 1'b0);
        for (int k = 1; k <= lat + 2; k++) begin
            @(posedge clk); #1;
            tests++; if (o_alu_en !== (k == 1)) begin fails++; $display("FAIL single_alu_en lat%0d k%0d: got %b exp %b", lat, k, o_alu_en, k == 1); end
            tests++; if (o_res_valid !== (k == lat + 2)) begin fails++; $display("FAIL single_res_valid lat%0d k%0d: got %b exp %b", lat, k, o_res_valid, k == lat + 2); end
            if (k == 1) begin
                tests++; if ({o_opcode, o_in_1, o_in_2} !== {3'd0, 4'h3, 4'h5}) begin fails++; $display("FAIL single_operands: got %h exp 035", {o_opcode, o_in_1, o_in_2}); end
            end
        end
        tests++; if (o_res_data !== 8'h08) begin fails++; $display("FAIL single_res_data: got %h exp 08", o_res_data); end
        @(posedge clk); #1;
        tests++; if ({o_res_valid, o_res_data} !== {1'b1, 8'h08}) begin fails++; $display("FAIL single_hold: got %h exp 108", {o_res_valid, o_res_data}); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_done[sel] += 1;
        tests++; if (o_res_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %b exp 0", o_res_valid); end
        tests++; if (o_done_cnt !== 8'(exp_done[sel])) begin fails++; $display("FAIL single_done_cnt: got %0d exp %0d", o_done_cnt, exp_done[sel]); end
    endtask

    task automatic test_back_to_back(input int lat);
        logic [2:0] vo [4];
        logic [3:0] va [4], vb [4];
        logic [7:0] ve [4], rd [4];
        int rc [4];
        int got = 0;
        vo = '{3'd0, 3'd1, 3'd5, 3'd4};
        va = '{4'h7, 4'h9, 4'hF, 4'hA};
        vb = '{4'h9, 4'h3, 4'hF, 4'h5};
        ve = '{8'h10, 8'h06, 8'hE1, 8'h0F};
        res_ready = 1'b1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (o_res_valid) begin rd[got] = o_res_data; rc[got] = c; got++; end
            cmd_valid = (c < 4);
            if (c < 4) begin cmd_op = vo[c]; cmd_a = va[c]; cmd_b = vb[c]; cmd_chain = 1'b0; end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        exp_done[sel] += 4;
        tests++; if (got != 4) begin fails++; $display("FAIL b2b_count lat%0d: got %0d exp 4", lat, got); end
        for (int i = 0; i < got; i++) begin
            tests++; if (rd[i] !== ve[i]) begin fails++; $display("FAIL b2b_data lat%0d #%0d: got %h exp %h", lat, i, rd[i], ve[i]); end
        end
        if (got > 0) begin
            tests++; if (rc[0] != 3 + lat) begin fails++; $display("FAIL b2b_latency lat%0d: got %0d exp %0d", lat, rc[0], 3 + lat); end
        end
        for (int i = 1; i < got; i++) begin
            tests++; if (rc[i] - rc[i-1] != lat + 2) begin fails++; $display("FAIL b2b_spacing lat%0d #%0d: got %0d exp %0d", lat, i, rc[i] - rc[i-1], lat + 2); end
        end
        tests++; if (o_done_cnt !== 8'(exp_done[sel])) begin fails++; $display("FAIL b2b_done_cnt lat%0d: got %0d exp %0d", lat, o_done_cnt, exp_done[sel]); end
        res_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [2:0] vo [6];
        logic [3:0] va [6], vb [6];
        logic [7:0] ve [6], rd [6];
        logic acc;
        int idx = 0, got = 0;
        vo = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0};
        va = '{4'h1, 4'hC, 4'hC, 4'h3, 4'hF, 4'h8};
        vb = '{4'h2, 4'hA, 4'hA, 4'h4, 4'h1, 4'h8};
        ve = '{8'h03, 8'h08, 8'h0E, 8'h0C, 8'h0E, 8'h10};
        res_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = (idx < 6);
            if (idx < 6) begin cmd_op = vo[idx]; cmd_a = va[idx]; cmd_b = vb[idx]; cmd_chain = 1'b0; end
            acc = cmd_valid && o_cmd_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        tests++; if (idx != 5) begin fails++; $display("FAIL full_accepted: got %0d exp 5", idx); end
        tests++; if ({o_cmd_ready, o_res_valid, o_busy} !== 3'b011) begin fails++; $display("FAIL full_state: got %b exp 011", {o_cmd_ready, o_res_valid, o_busy}); end
        res_ready = 1'b1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (o_res_valid) begin rd[got] = o_res_data; got++; end
            cmd_valid = (idx < 6);
            if (idx < 6) begin cmd_op = vo[idx]; cmd_a = va[idx]; cmd_b = vb[idx]; cmd_chain = 1'b0; end
            acc = cmd_valid && o_cmd_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_done[0] += 6;
        tests++; if (got != 6) begin fails++; $display("FAIL full_results: got %0d exp 6", got); end
        for (int i = 0; i < got; i++) begin
            tests++; if (rd[i] !== ve[i]) begin fails++; $display("FAIL full_data #%0d: got %h exp %h", i, rd[i], ve[i]); end
        end
        tests++; if (o_done_cnt !== 8'(exp_done[0])) begin fails++; $display("FAIL full_done_cnt: got %0d exp %0d", o_done_cnt, exp_done[0]); end
    endtask

    task automatic test_chain();
        logic [3:0] va [3], vb [3], ei [3], ri [3];
        logic [0:0] vc [3];
        logic [7:0] ve [3], rd [3];
        int ni = 0, got = 0;
        va = '{4'hF, 4'h2, 4'hF};
        vb = '{4'h7, 4'h2, 4'h1};
        vc = '{1'b1, 1'b0, 1'b1};
        ei = '{4'h0, 4'h2, 4'h4};
        ve = '{8'h07, 8'h04, 8'h05};
        pulse_reset();
        res_ready = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            if (o_res_valid) begin rd[got] = o_res_data; got++; end
            if (o_alu_en && ni < 3) begin ri[ni] = o_in_1; ni++; end
            cmd_valid = (c < 3);
            if (c < 3) begin cmd_op = 3'd0; cmd_a = va[c]; cmd_b = vb[c]; cmd_chain = vc[c][0]; end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_done[0] += 3;
        tests++; if (got != 3 || ni != 3) begin fails++; $display("FAIL chain_count: got %0d/%0d exp 3/3", got, ni); end
        for (int i = 0; i < ni; i++) begin
            tests++; if (ri[i] !== ei[i]) begin fails++; $display("FAIL chain_in_1 #%0d: got %h exp %h", i, ri[i], ei[i]); end
        end
        for (int i = 0; i < got; i++) begin
            tests++; if (rd[i] !== ve[i]) begin fails++; $display("FAIL chain_data #%0d: got %h exp %h", i, rd[i], ve[i]); end
        end
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, bad = 0;
        logic acc;
        logic [7:0] ev;
        pulse_reset();
        res_ready = 1'b1;
        for (int c = 0; c < 3000 && got < 300; c++) begin
            if (o_res_valid) begin
                ev = 8'((got % 16) + ((got / 16) % 16));
                if (o_res_data !== ev) begin
                    bad++;
                    if (bad < 4) $display("FAIL wrap_data #%0d: got %h exp %h", got, o_res_data, ev);
                end
                got++;
            end
            cmd_valid = (sent < 300);
            cmd_op = 3'd0; cmd_a = 4'(sent % 16); cmd_b = 4'((sent / 16) % 16); cmd_chain = 1'b0;
            acc = cmd_valid && o_cmd_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        tests++; if (got != 300) begin fails++; $display("FAIL wrap_count: got %0d exp 300", got); end
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_mismatches: got %0d exp 0", bad); end
        tests++; if (o_done_cnt !== 8'd44) begin fails++; $display("FAIL wrap_done_cnt: got %0d exp 44", o_done_cnt); end
        tests++; if ({o_busy, o_cmd_ready} !== 2'b01) begin fails++; $display("FAIL wrap_idle: got %b exp 01", {o_busy, o_cmd_ready}); end
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        exp_done[0] = 0; exp_done[1] = 0;
        test_reset();
        test_single(1);
        test_back_to_back(1);
        test_full();
        test_chain();
        test_wrap();
        sel = 1'b1;
        @(posedge clk); #1;
        test_single(3);
        test_back_to_back(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
